// File: rtl/frame_pkg.sv
// Shared types and helpers for the frame buffer write path.
package frame_pkg;

    typedef enum logic [1:0] {IDLE, SKIP, WRITE, DONE} frame_state_t;

    localparam int DEF_ROW_W          = 15;
    localparam int DEF_COL_W          = 10;
    localparam int DEF_NUM_FRAMES     = 16;
    localparam int DEF_ROWS_PER_FRAME = 300;
    localparam int RING_ROWS          = DEF_NUM_FRAMES * DEF_ROWS_PER_FRAME;
    localparam int ADDR_W             = DEF_ROW_W + DEF_COL_W;

    // Base row of the slot after 'base', wrapping to slot 0 at the end of the ring.
    function automatic int unsigned next_frame_base(input int unsigned base,
                                                    input int unsigned rows_per_frame,
                                                    input int unsigned ring_rows);
        int unsigned nxt;
        nxt = base + rows_per_frame;
        return (nxt >= ring_rows) ? 0 : nxt;
    endfunction

endpackage

// File: rtl/frame_addr_gen.sv
// Pixel/column/row counters within a frame slot and the ring of slot base rows.
module frame_addr_gen
    import frame_pkg::*;
#(
    parameter int ROW_W            = DEF_ROW_W,
    parameter int COL_W            = DEF_COL_W,
    parameter int NUM_FRAMES       = DEF_NUM_FRAMES,
    parameter int ROWS_PER_FRAME   = DEF_ROWS_PER_FRAME,
    parameter int PIXELS_PER_FRAME = 307200
) (
    input  logic                   ram_clk,
    input  logic                   reset,
    input  logic                   advance,
    input  logic                   restart,
    input  logic                   commit,
    output logic [ROW_W+COL_W-1:0] address,
    output logic                   last_pixel,
    output logic [ROW_W-1:0]       frame_base
);

    localparam int CNT_W = $clog2(PIXELS_PER_FRAME + 1);

    logic [ROW_W-1:0] row_off, row_cur;
    logic [COL_W-1:0] col_off, col_cur;
    logic [CNT_W-1:0] pix_cnt, cnt_cur;

    // A restart writes the current pixel as pixel 0, so it sees zeroed counters.
    always_comb begin
        row_cur = restart ? '0 : row_off;
        col_cur = restart ? '0 : col_off;
        cnt_cur = restart ? '0 : pix_cnt;
    end

    assign address    = {frame_base + row_cur, col_cur};
    assign last_pixel = (pix_cnt == CNT_W'(PIXELS_PER_FRAME - 1));

    always_ff @(posedge ram_clk or negedge reset) begin
        if (!reset) begin
            frame_base <= '0;
            row_off    <= '0;
            col_off    <= '0;
            pix_cnt    <= '0;
        end else if (commit) begin
            frame_base <= ROW_W'(next_frame_base(32'(frame_base), ROWS_PER_FRAME,
                                                 NUM_FRAMES * ROWS_PER_FRAME));
            row_off    <= '0;
            col_off    <= '0;
            pix_cnt    <= '0;
        end else if (advance || restart) begin
            col_off <= col_cur + 1'b1;
            row_off <= (&col_cur) ? row_cur + 1'b1 : row_cur;
            pix_cnt <= cnt_cur + 1'b1;
        end
    end

endmodule

// File: rtl/frame_writer.sv
// Writes a valid/ready pixel stream into a ring of SDRAM frame slots, one write command per pixel.
module frame_writer
    import frame_pkg::*;
#(
    parameter int PIX_W            = 10,
    parameter int DATA_W           = 16,
    parameter int ROW_W            = DEF_ROW_W,
    parameter int COL_W            = DEF_COL_W,
    parameter int NUM_FRAMES       = DEF_NUM_FRAMES,
    parameter int ROWS_PER_FRAME   = DEF_ROWS_PER_FRAME,
    parameter int PIXELS_PER_FRAME = 307200,
    parameter int REFRESH_GUARD    = 100
) (
    input  logic                   ram_clk,
    input  logic                   reset,
    input  logic                   pix_valid,
    input  logic [PIX_W-1:0]       pix_data,
    input  logic                   pix_sof,
    output logic                   pix_ready,
    input  logic                   capture_en,
    input  logic [7:0]             interval,
    input  logic                   ram_busy,
    input  logic [9:0]             refreshCountdown,
    output logic                   write,
    output logic                   isWrite,
    output logic [ROW_W+COL_W-1:0] address,
    output logic [1:0]             writeMask,
    output logic [DATA_W-1:0]      writeData,
    output logic [ROW_W-1:0]       lastframe,
    output logic                   frame_done,
    output logic                   frame_abort,
    output logic                   keepOpen
);

    localparam bit SINGLE_PIX = (PIXELS_PER_FRAME == 1);

    if (64'(NUM_FRAMES) * 64'(ROWS_PER_FRAME) > (64'd1 << ROW_W)) begin : g_ring_overflow
        $error("frame_writer: frame ring does not fit in ROW_W row bits");
    end
    if (64'(ROWS_PER_FRAME) * (64'd1 << COL_W) < 64'(PIXELS_PER_FRAME)) begin : g_slot_small
        $error("frame_writer: frame slot too small for PIXELS_PER_FRAME");
    end
    if (DATA_W < PIX_W) begin : g_data_narrow
        $error("frame_writer: DATA_W narrower than PIX_W");
    end

    frame_state_t state, state_next;
    logic [7:0]             skip_cnt;
    logic                   accept, emit, advance, restart, commit, abort, skip_dec;
    logic                   last_pixel;
    logic [ROW_W+COL_W-1:0] gen_addr;
    logic [ROW_W-1:0]       frame_base;

    frame_addr_gen #(
        .ROW_W            (ROW_W),
        .COL_W            (COL_W),
        .NUM_FRAMES       (NUM_FRAMES),
        .ROWS_PER_FRAME   (ROWS_PER_FRAME),
        .PIXELS_PER_FRAME (PIXELS_PER_FRAME)
    ) u_addr_gen (
        .ram_clk    (ram_clk),
        .reset      (reset),
        .advance    (advance),
        .restart    (restart),
        .commit     (commit),
        .address    (gen_addr),
        .last_pixel (last_pixel),
        .frame_base (frame_base)
    );

    assign isWrite   = 1'b1;
    assign writeMask = 2'b11;
    assign keepOpen  = (refreshCountdown > 10'(REFRESH_GUARD));

    // Outside WRITE the stream is drained so the upstream FIFO never stalls.
    always_comb begin
        pix_ready = 1'b0;
        case (state)
            IDLE, SKIP: pix_ready = 1'b1;
            WRITE:      pix_ready = ~ram_busy;
            default:    pix_ready = 1'b0;
        endcase
    end

    assign accept = pix_valid & pix_ready;

    always_comb begin
        state_next = state;
        emit       = 1'b0;
        advance    = 1'b0;
        restart    = 1'b0;
        commit     = 1'b0;
        abort      = 1'b0;
        skip_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (accept && pix_sof && capture_en) begin
                    if (skip_cnt == 8'd0) begin
                        restart    = 1'b1;
                        emit       = 1'b1;
                        state_next = SINGLE_PIX ? DONE : WRITE;
                    end else begin
                        skip_dec   = 1'b1;
                        state_next = SKIP;
                    end
                end
            end
            SKIP: state_next = IDLE;
            WRITE: begin
                if (accept) begin
                    emit = 1'b1;
                    if (pix_sof) begin
                        restart = 1'b1;
                        abort   = 1'b1;
                    end else begin
                        advance = 1'b1;
                    end
                    if (pix_sof ? SINGLE_PIX : last_pixel) state_next = DONE;
                end
            end
            DONE: begin
                commit     = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge ram_clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            skip_cnt <= 8'd0;
        end else begin
            state <= state_next;
            if (commit)        skip_cnt <= interval;
            else if (skip_dec) skip_cnt <= skip_cnt - 8'd1;
        end
    end

    // Command outputs hold their last address/data between writes.
    always_ff @(posedge ram_clk or negedge reset) begin
        if (!reset) begin
            write       <= 1'b0;
            address     <= '0;
            writeData   <= '0;
            lastframe   <= '0;
            frame_done  <= 1'b0;
            frame_abort <= 1'b0;
        end else begin
            write       <= emit;
            frame_done  <= commit;
            frame_abort <= abort;
            if (emit) begin
                address   <= gen_addr;
                writeData <= DATA_W'(pix_data);
            end
            if (commit) lastframe <= frame_base;
        end
    end

endmodule

// File: tb/tb_frame_writer.sv
// Self-checking bench for frame_writer: directed tables and sequences plus random stimulus vs a frame-level model.
module tb_frame_writer;

    localparam int PIX_W  = 10;
    localparam int DATA_W = 16;
    localparam int ROW_W  = 15;
    localparam int COL_W  = 2;
    localparam int NF     = 2;
    localparam int RPF    = 2;
    localparam int PPF    = 8;
    localparam int GUARD  = 100;
    localparam int COLS   = 1 << COL_W;
    localparam int RING   = NF * RPF;
    localparam int AW     = ROW_W + COL_W;

    logic              ram_clk, reset;
    logic              pix_valid, pix_sof, pix_ready, capture_en, ram_busy;
    logic [PIX_W-1:0]  pix_data;
    logic [7:0]        interval;
    logic [9:0]        refreshCountdown;
    logic              write, isWrite, frame_done, frame_abort, keepOpen;
    logic [AW-1:0]     address;
    logic [1:0]        writeMask;
    logic [DATA_W-1:0] writeData;
    logic [ROW_W-1:0]  lastframe;

    frame_writer #(
        .PIX_W (PIX_W), .DATA_W (DATA_W), .ROW_W (ROW_W), .COL_W (COL_W),
        .NUM_FRAMES (NF), .ROWS_PER_FRAME (RPF), .PIXELS_PER_FRAME (PPF),
        .REFRESH_GUARD (GUARD)
    ) dut (
        .ram_clk (ram_clk), .reset (reset), .pix_valid (pix_valid), .pix_data (pix_data),
        .pix_sof (pix_sof), .pix_ready (pix_ready), .capture_en (capture_en),
        .interval (interval), .ram_busy (ram_busy), .refreshCountdown (refreshCountdown),
        .write (write), .isWrite (isWrite), .address (address), .writeMask (writeMask),
        .writeData (writeData), .lastframe (lastframe), .frame_done (frame_done),
        .frame_abort (frame_abort), .keepOpen (keepOpen)
    );

    initial ram_clk = 1'b0;
    always #5 ram_clk = ~ram_clk;

    int checks = 0;
    int errors = 0;
    int n_writes, n_dones, n_aborts;

    // Frame-level reference model state
    bit m_in_frame, m_done_pending, m_skip_cycle;
    int m_idx, m_base, m_skip, m_last;
    bit e_write, e_done, e_abort;
    logic [AW-1:0]     e_addr;
    logic [DATA_W-1:0] e_data;

    typedef struct { logic sof; logic [PIX_W-1:0] data; int row; int col; } basic_vec_t;
    typedef struct { logic [9:0] rc; logic ko; } keep_vec_t;
    basic_vec_t basic_tbl[PPF];
    keep_vec_t  keep_tbl[6];

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        m_in_frame = 0; m_done_pending = 0; m_skip_cycle = 0;
        m_idx = 0; m_base = 0; m_skip = 0; m_last = 0;
        e_write = 0; e_done = 0; e_abort = 0; e_addr = '0; e_data = '0;
        n_writes = 0; n_dones = 0; n_aborts = 0;
    endtask

    task automatic modelWrite(input logic [PIX_W-1:0] d);
        e_write = 1;
        e_addr  = AW'(((m_base + m_idx / COLS) << COL_W) | (m_idx % COLS));
        e_data  = DATA_W'(d);
        m_idx++;
        if (m_idx == PPF) begin
            m_in_frame     = 0;
            m_done_pending = 1;
        end
    endtask

    task automatic modelStep(input bit acc, input logic s, input logic [PIX_W-1:0] d, input logic cap);
        e_write = 0; e_done = 0; e_abort = 0;
        if (m_done_pending) begin
            e_done         = 1;
            m_last         = m_base;
            m_base         = (m_base + RPF >= RING) ? 0 : m_base + RPF;
            m_skip         = int'(interval);
            m_done_pending = 0;
        end else if (m_skip_cycle) begin
            m_skip_cycle = 0;
        end else if (acc) begin
            if (m_in_frame) begin
                if (s) begin
                    e_abort = 1;
                    m_idx   = 0;
                end
                modelWrite(d);
            end else if (s && cap) begin
                if (m_skip == 0) begin
                    m_in_frame = 1;
                    m_idx      = 0;
                    modelWrite(d);
                end else begin
                    m_skip--;
                    m_skip_cycle = 1;
                end
            end
        end
    endtask

    task automatic checkOutput();
        checkValue("write", 32'(write), 32'(e_write));
        checkValue("address", 32'(address), 32'(e_addr));
        checkValue("writeData", 32'(writeData), 32'(e_data));
        checkValue("frame_done", 32'(frame_done), 32'(e_done));
        checkValue("frame_abort", 32'(frame_abort), 32'(e_abort));
        checkValue("lastframe", 32'(lastframe), 32'(m_last));
    endtask

    task automatic applyStimulus(input logic v, input logic s, input logic [PIX_W-1:0] d,
                                 input logic b, input logic cap);
        bit exp_ready;
        @(negedge ram_clk);
        pix_valid = v; pix_sof = s; pix_data = d; ram_busy = b; capture_en = cap;
        #1;
        exp_ready = m_done_pending ? 1'b0 : (m_in_frame ? !b : 1'b1);
        checkValue("pix_ready", 32'(pix_ready), 32'(exp_ready));
        modelStep(v && exp_ready, s, d, cap);
        @(posedge ram_clk);
        #1;
        checkOutput();
        if (write === 1'b1)       n_writes++;
        if (frame_done === 1'b1)  n_dones++;
        if (frame_abort === 1'b1) n_aborts++;
    endtask

    // Asserted between clock edges so the asynchronous clear is visible at once.
    task automatic doReset();
        #2;
        reset = 1'b0;
        #1;
        checkValue("reset_write", 32'(write), 32'd0);
        checkValue("reset_lastframe", 32'(lastframe), 32'd0);
        modelReset();
        checkOutput();
        checkValue("reset_ready", 32'(pix_ready), 32'd1);
        @(negedge ram_clk);
        pix_valid = 0; pix_sof = 0; pix_data = '0; ram_busy = 0; capture_en = 1;
        @(negedge ram_clk);
        reset = 1'b1;
    endtask

    task automatic sendFrame(input int first);
        for (int i = 0; i < PPF; i++)
            applyStimulus(1'b1, i == 0, PIX_W'(first + i), 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
    endtask

    initial begin
        int wrap_exp[3];
        reset = 1'b0; pix_valid = 0; pix_sof = 0; pix_data = '0; ram_busy = 0;
        capture_en = 1; interval = 8'd0; refreshCountdown = 10'd0;
        modelReset();
        @(negedge ram_clk);
        doReset();

        // Basic frame
        for (int i = 0; i < PPF; i++) begin
            basic_tbl[i].sof  = (i == 0);
            basic_tbl[i].data = PIX_W'(i + 1);
            basic_tbl[i].row  = i / 4;
            basic_tbl[i].col  = i % 4;
        end
        for (int i = 0; i < PPF; i++) begin
            applyStimulus(1'b1, basic_tbl[i].sof, basic_tbl[i].data, 1'b0, 1'b1);
            checkValue("basic_addr", 32'(address), 32'((basic_tbl[i].row << 2) | basic_tbl[i].col));
            checkValue("basic_data", 32'(writeData), 32'(basic_tbl[i].data));
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkValue("basic_done_count", 32'(n_dones), 32'd1);
        checkValue("basic_lastframe", 32'(lastframe), 32'd0);

        // Ring wrap
        doReset();
        wrap_exp = '{0, 2, 0};
        for (int f = 0; f < 3; f++) begin
            sendFrame(10 * f + 1);
            checkValue("wrap_lastframe", 32'(lastframe), 32'(wrap_exp[f]));
        end

        // Backpressure
        doReset();
        for (int i = 1; i <= 3; i++) applyStimulus(1'b1, i == 1, PIX_W'(i), 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, 1'b0, PIX_W'(4), 1'b1, 1'b1);
            checkValue("bp_ready", 32'(pix_ready), 32'd0);
            checkValue("bp_no_write", 32'(write), 32'd0);
        end
        for (int i = 4; i <= 8; i++) applyStimulus(1'b1, 1'b0, PIX_W'(i), 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkValue("bp_writes", 32'(n_writes), 32'd8);
        checkValue("bp_dones", 32'(n_dones), 32'd1);

        // Short frame
        doReset();
        for (int i = 1; i <= 4; i++) applyStimulus(1'b1, i == 1, PIX_W'(i), 1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1, PIX_W'(11), 1'b0, 1'b1);
        checkValue("short_abort", 32'(frame_abort), 32'd1);
        checkValue("short_sof_addr", 32'(address), 32'd0);
        for (int i = 12; i <= 18; i++) begin
            applyStimulus(1'b1, 1'b0, PIX_W'(i), 1'b0, 1'b1);
            if (i < 18) checkValue("short_lastframe_hold", 32'(n_dones), 32'd0);
        end
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, '0, 1'b0, 1'b1);
        checkValue("short_aborts", 32'(n_aborts), 32'd1);
        checkValue("short_dones", 32'(n_dones), 32'd1);

        // Decimation
        doReset();
        interval = 8'd2;
        for (int f = 0; f < 6; f++) sendFrame(20 * f + 1);
        checkValue("decim_writes", 32'(n_writes), 32'd16);
        checkValue("decim_dones", 32'(n_dones), 32'd2);
        interval = 8'd0;

        // Reset mid-frame after two committed frames
        doReset();
        sendFrame(1);
        sendFrame(41);
        checkValue("rst_pre_lastframe", 32'(lastframe), 32'd2);
        for (int i = 0; i < 4; i++) applyStimulus(1'b1, i == 0, PIX_W'(60 + i), 1'b0, 1'b1);
        doReset();

        // keepOpen threshold
        keep_tbl = '{'{10'd0, 1'b0}, '{10'd100, 1'b0}, '{10'd101, 1'b1},
                     '{10'd99, 1'b0}, '{10'd1023, 1'b1}, '{10'd500, 1'b1}};
        for (int i = 0; i < 6; i++) begin
            refreshCountdown = keep_tbl[i].rc;
            #1;
            checkValue("keepOpen", 32'(keepOpen), 32'(keep_tbl[i].ko));
        end

        // Random traffic
        doReset();
        for (int i = 0; i < 3000; i++) begin
            if (i % 500 == 0) interval = 8'($urandom_range(0, 2));
            applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 11) == 0,
                          PIX_W'($urandom), $urandom_range(0, 3) == 0,
                          $urandom_range(0, 7) != 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/frame_writer.md
Name: frame_writer

Overview:
- Single-clock successor to the camera frame buffer write path. Accepts a pixel stream already in the ram_clk domain, behind the cam/ram CDC FIFO, using a valid/ready handshake with start-of-frame marking.
- Writes complete frames into an N-slot ring of SDRAM frame slots and issues one registered write command per pixel.
- Supports frame-rate decimation, short-frame abort, and SDRAM backpressure.
- Publishes the base row of the last completely written frame for the read/display side.

Parameters:
- PIX_W, 10: pixel data width.
- DATA_W, 16: SDRAM word width. Pixel is zero-extended into the word.
- ROW_W, 15: SDRAM row address width.
- COL_W, 10: SDRAM column address width.
- NUM_FRAMES, 16: number of frame slots in the ring.
- ROWS_PER_FRAME, 300: SDRAM rows reserved per slot. Must satisfy ROWS_PER_FRAME*2^COL_W >= PIXELS_PER_FRAME.
- PIXELS_PER_FRAME, 307200: pixels in one complete frame.
- REFRESH_GUARD, 100: keepOpen threshold on refreshCountdown.

Ports:
- ram_clk, input, 1: the only clock.
- reset, input, 1: asynchronous, active-low reset.
- pix_valid, input, 1: pixel present on pix_data.
- pix_data, input, PIX_W: pixel value.
- pix_sof, input, 1: qualifies pix_data as the first pixel of a frame.
- pix_ready, output, 1: frame_writer accepts the pixel this cycle.
- capture_en, input, 1: enables capture of new frames.
- interval, input, 8: number of frames skipped after each captured frame.
- ram_busy, input, 1: SDRAM cannot take a command issued next cycle.
- refreshCountdown, input, 10: cycles until the next SDRAM refresh.
- write, output, 1: command valid.
- isWrite, output, 1: command is a write. Tied to 1.
- address, output, ROW_W+COL_W: {row, column}.
- writeMask, output, 2: tied to 2'b11.
- writeData, output, DATA_W: zero-extended pixel.
- lastframe, output, ROW_W: base row of the newest complete frame.
- frame_done, output, 1: one-cycle pulse when a frame commits.
- frame_abort, output, 1: one-cycle pulse on a short frame.
- keepOpen, output, 1: combinational, refreshCountdown > REFRESH_GUARD.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; frame_base=0, row_off=0, col_off=0, pix_cnt=0, skip_cnt=0.
  - write=0, address=0, writeData=0, lastframe=0, frame_done=0, frame_abort=0.
  - Reset in the middle of a frame discards that frame; lastframe returns to 0.
- Accept: a pixel is accepted when pix_valid && pix_ready.
- pix_ready:
  - IDLE and SKIP: pix_ready=1; pixels are discarded.
  - WRITE: pix_ready=~ram_busy.
- Latency: one cycle. The cycle after an accept in WRITE:
  - write=1;
  - address={frame_base+row_off, col_off};
  - writeData=pix_data.
  - Otherwise write=0; address and writeData hold their last values.
- State machine:
  - IDLE -> WRITE: pix_sof accepted, capture_en=1, skip_cnt=0. That pixel is written at column 0, row offset 0.
  - IDLE -> SKIP: pix_sof accepted, capture_en=1, skip_cnt!=0. skip_cnt decrements.
  - IDLE: non-sof pixels are dropped. capture_en=0 keeps the block in IDLE.
  - SKIP -> IDLE: the cycle after the accept that leaves the block in SKIP, so the next sof is evaluated in IDLE.
  - WRITE, accepted non-sof pixel: col_off increments. At col_off=2^COL_W-1 it wraps to 0 and row_off increments. pix_cnt increments.
  - WRITE -> DONE: accept with pix_cnt=PIXELS_PER_FRAME-1.
  - WRITE, accepted pix_sof before the frame is complete:
    - frame_abort pulses; nothing is committed;
    - pix_cnt, row_off and col_off restart; frame_base is unchanged;
    - the sof pixel is written as pixel 0 and the block stays in WRITE.
  - DONE -> IDLE, after one cycle with pix_ready=0:
    - lastframe<=frame_base; frame_done pulses; skip_cnt<=interval;
    - frame_base<=frame_base+ROWS_PER_FRAME, or 0 if that value >= NUM_FRAMES*ROWS_PER_FRAME.
- capture_en falling during WRITE does not stop the current frame; it completes.
- Extra pixels after a complete frame and before the next sof are dropped in IDLE.
- Arithmetic: frame_base and row addition in ROW_W bits. Parameters guarantee no overflow, checked by an elaboration assertion.
- Simultaneous ram_busy=1 and a sof in WRITE: not accepted, no abort until accepted.

Decomposition:
- Package frame_pkg:
  - state enum {IDLE, SKIP, WRITE, DONE};
  - localparams RING_ROWS=NUM_FRAMES*ROWS_PER_FRAME and ADDR_W=ROW_W+COL_W;
  - a function computing the next frame_base with wrap.
- Sub-module frame_addr_gen: col/row/pix counters and the frame_base ring. It takes advance/restart/commit strobes and returns address and last_pixel.

Test Plan:
All scenarios use NUM_FRAMES=2, ROWS_PER_FRAME=2, COL_W=2, PIXELS_PER_FRAME=8, interval=0.
- Basic frame: sof plus 7 pixels, values 1..8 -> writes to {0,0},{0,1},{0,2},{0,3},{1,0}..{1,3} with data 1..8. frame_done pulses once; lastframe=0.
- Ring wrap: three full frames -> bases 0, 2, 0; lastframe sequence 0, 2, 0.
- Backpressure: ram_busy=1 for 3 cycles mid-frame -> pix_ready=0 during those cycles, no write, no lost or duplicated pixel. Address sequence identical to the basic frame.
- Short frame: sof, 3 pixels, then sof -> frame_abort pulses once; the new sof pixel is written at {0,0}; lastframe unchanged until 8 pixels complete.
- Decimation: interval=2 with 6 frames -> frames 1 and 4 written; frame_done pulses twice; only 16 writes total.
- Reset and keepOpen: reset=0 mid-frame -> write=0, lastframe=0 immediately. refreshCountdown of 100 -> keepOpen=0; 101 -> keepOpen=1.
